loop_apu_engine: RTL and testbench

- Parametrised nested-loop sequencer with multi-channel address processing unit (APU).
- Generalises the control unit's single loop counter and fixed APU pair to a STACK_DEPTH-deep loop stack and NUM_APU address channels, recomputed after every loop event.
- Control unit issues START/END loop commands over a valid/ready handshake and receives next-PC/jump responses.
- Channel addresses feed cache/main-memory addressing for queued RAM and load/store instructions.

---
 rtl/loop_apu_engine_pkg.sv | 36 +++
 rtl/apu_mac_stage.sv | 18 +
 rtl/loop_apu_engine.sv | 233 +++++++++++++++++++++++
 tb/tb_loop_apu_engine.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_apu_engine_pkg.sv
// Shared types for the nested-loop sequencer: command encoding, FSM states and loop-stack frames.
package loop_apu_engine_pkg;

    localparam int DEF_LOG_LOOP_CNT = 3;
    localparam int DEF_STACK_DEPTH  = 4;
    localparam int DEF_NUM_APU      = 4;
    localparam int DEF_ADDR_W       = 18;
    localparam int DEF_ITER_W       = 12;
    localparam int DEF_PC_W         = 16;

    typedef enum logic {
        START_LOOP = 1'b0,
        END_LOOP   = 1'b1
    } loop_cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        READY,
        PUSH,
        INCR,
        APU,
        RESPOND
    } state_e;

    typedef struct packed {
        logic [DEF_LOG_LOOP_CNT-1:0] slot;
        logic [DEF_PC_W-1:0]         start_pc;
        logic [DEF_ITER_W-1:0]       iter_var;
    } loop_frame_t;

    // A programmed count of zero still runs the body once.
    function automatic logic [DEF_ITER_W-1:0] eff_iters(input logic [DEF_ITER_W-1:0] iters);
        return (iters == '0) ? DEF_ITER_W'(1) : iters;
    endfunction

endpackage

// File: rtl/apu_mac_stage.sv
// One address channel step: acc_out = acc_in + stride*iter_var, wrapping modulo 2**ADDR_W.
module apu_mac_stage #(
    parameter int ADDR_W = 18,
    parameter int ITER_W = 12
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] acc_in,
    input  logic [ADDR_W-1:0] stride,
    input  logic [ITER_W-1:0] iter_var,
    output logic [ADDR_W-1:0] acc_out
);

    logic [ADDR_W+ITER_W-1:0] prod;

    assign prod    = stride * iter_var;
    assign acc_out = en ? (acc_in + prod[ADDR_W-1:0]) : acc_in;

endmodule

// File: rtl/loop_apu_engine.sv
// Nested-loop sequencer: a loop stack driven by START/END commands, with per-channel
// address recomputation (one stack level per cycle) after every accepted loop event.
module loop_apu_engine
    import loop_apu_engine_pkg::*;
#(
    parameter int LOG_LOOP_CNT = DEF_LOG_LOOP_CNT,
    parameter int STACK_DEPTH  = DEF_STACK_DEPTH,
    parameter int NUM_APU      = DEF_NUM_APU,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int ITER_W       = DEF_ITER_W,
    parameter int PC_W         = DEF_PC_W
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        prog_load,
    input  logic [(2**LOG_LOOP_CNT)*ITER_W-1:0]         prog_iters,
    input  logic [NUM_APU*(2**LOG_LOOP_CNT)*ADDR_W-1:0] prog_strides,
    input  logic [NUM_APU*ADDR_W-1:0]                   prog_bases,
    input  logic                                        cmd_valid,
    output logic                                        cmd_ready,
    input  logic                                        cmd_op,
    input  logic [LOG_LOOP_CNT-1:0]                     cmd_loop_addr,
    input  logic [PC_W-1:0]                             cmd_pc,
    output logic                                        rsp_valid,
    output logic                                        rsp_jump,
    output logic [PC_W-1:0]                             rsp_pc,
    output logic                                        rsp_error,
    output logic [NUM_APU*ADDR_W-1:0]                   apu_addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]            loop_depth,
    output logic                                        error
);

    localparam int LOOP_SLOTS = 2**LOG_LOOP_CNT;
    localparam int DEPTH_W    = $clog2(STACK_DEPTH+1);
    localparam int IDX_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    state_e             state_q, state_d;
    loop_frame_t        stack_q [STACK_DEPTH];
    loop_frame_t        stack_d [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [DEPTH_W-1:0] apu_idx_q, apu_idx_d;
    logic [LOG_LOOP_CNT-1:0] slot_q, slot_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    rsp_pc_q, rsp_pc_d;
    logic               rsp_jump_q, rsp_jump_d;
    logic               rsp_error_q, rsp_error_d;
    logic               error_q, error_d;

    logic [ITER_W-1:0]  iters_q   [LOOP_SLOTS];
    logic [ITER_W-1:0]  iters_d   [LOOP_SLOTS];
    logic [ADDR_W-1:0]  strides_q [NUM_APU][LOOP_SLOTS];
    logic [ADDR_W-1:0]  strides_d [NUM_APU][LOOP_SLOTS];
    logic [ADDR_W-1:0]  bases_q   [NUM_APU];
    logic [ADDR_W-1:0]  bases_d   [NUM_APU];
    logic [ADDR_W-1:0]  acc_q     [NUM_APU];
    logic [ADDR_W-1:0]  acc_d     [NUM_APU];
    logic [ADDR_W-1:0]  apu_addr_q[NUM_APU];
    logic [ADDR_W-1:0]  apu_addr_d[NUM_APU];
    logic [ADDR_W-1:0]  mac_out   [NUM_APU];

    loop_frame_t        top_frame;
    logic [IDX_W-1:0]   push_idx, top_idx, lvl_idx;
    logic               lvl_en, apu_last, load_cfg;
    logic [ITER_W:0]    next_var;

    assign push_idx  = IDX_W'(depth_q);
    assign top_idx   = IDX_W'(depth_q - DEPTH_W'(1));
    assign lvl_idx   = IDX_W'(apu_idx_q);
    assign top_frame = stack_q[top_idx];
    assign lvl_en    = apu_idx_q < depth_q;
    // An empty stack still spends one APU cycle, which reloads the bases.
    assign apu_last  = (depth_q == '0) || (apu_idx_q == depth_q - DEPTH_W'(1));
    assign next_var  = {1'b0, top_frame.iter_var} + (ITER_W+1)'(1);

    for (genvar gi = 0; gi < NUM_APU; gi++) begin : g_chan
        logic [ADDR_W-1:0] acc_in;

        assign acc_in = (apu_idx_q == '0) ? bases_q[gi] : acc_q[gi];

        apu_mac_stage #(
            .ADDR_W(ADDR_W),
            .ITER_W(ITER_W)
        ) u_mac (
            .en      (lvl_en),
            .acc_in  (acc_in),
            .stride  (strides_q[gi][stack_q[lvl_idx].slot]),
            .iter_var(stack_q[lvl_idx].iter_var),
            .acc_out (mac_out[gi])
        );

        assign apu_addr[gi*ADDR_W +: ADDR_W] = apu_addr_q[gi];
    end

    always_comb begin
        state_d     = state_q;
        stack_d     = stack_q;
        depth_d     = depth_q;
        apu_idx_d   = apu_idx_q;
        slot_d      = slot_q;
        pc_d        = pc_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_jump_d  = rsp_jump_q;
        rsp_error_d = rsp_error_q;
        error_d     = error_q;
        iters_d     = iters_q;
        strides_d   = strides_q;
        bases_d     = bases_q;
        acc_d       = acc_q;
        apu_addr_d  = apu_addr_q;
        load_cfg    = 1'b0;

        case (state_q)
            IDLE: load_cfg = prog_load;
            READY: begin
                if (cmd_valid) begin
                    slot_d  = cmd_loop_addr;
                    pc_d    = cmd_pc;
                    state_d = (loop_cmd_e'(cmd_op) == END_LOOP) ? INCR : PUSH;
                end else begin
                    load_cfg = prog_load;
                end
            end
            PUSH: begin
                rsp_jump_d = 1'b0;
                rsp_pc_d   = pc_q + PC_W'(1);
                if (depth_q == DEPTH_W'(STACK_DEPTH)) begin
                    error_d     = 1'b1;
                    rsp_error_d = 1'b1;
                    state_d     = RESPOND;
                end else begin
                    stack_d[push_idx] = '{slot: slot_q, start_pc: pc_q, iter_var: '0};
                    depth_d     = depth_q + DEPTH_W'(1);
                    rsp_error_d = 1'b0;
                    apu_idx_d   = '0;
                    state_d     = APU;
                end
            end
            INCR: begin
                rsp_jump_d  = 1'b0;
                rsp_error_d = 1'b0;
                rsp_pc_d    = pc_q + PC_W'(1);
                if (depth_q == '0) begin
                    error_d     = 1'b1;
                    rsp_error_d = 1'b1;
                    state_d     = RESPOND;
                end else begin
                    if (next_var < {1'b0, eff_iters(iters_q[top_frame.slot])}) begin
                        stack_d[top_idx].iter_var = next_var[ITER_W-1:0];
                        rsp_jump_d = 1'b1;
                        rsp_pc_d   = top_frame.start_pc + PC_W'(1);
                    end else begin
                        depth_d = depth_q - DEPTH_W'(1);
                    end
                    apu_idx_d = '0;
                    state_d   = APU;
                end
            end
            APU: begin
                acc_d = mac_out;
                if (apu_last) begin
                    apu_addr_d = mac_out;
                    state_d    = RESPOND;
                end else begin
                    apu_idx_d = apu_idx_q + DEPTH_W'(1);
                end
            end
            RESPOND: state_d = READY;
            default: state_d = IDLE;
        endcase

        // A new program starts from an empty stack so apu_addr == bases stays consistent.
        if (load_cfg) begin
            for (int s = 0; s < LOOP_SLOTS; s++) begin
                iters_d[s] = prog_iters[s*ITER_W +: ITER_W];
            end
            for (int c = 0; c < NUM_APU; c++) begin
                bases_d[c]    = prog_bases[c*ADDR_W +: ADDR_W];
                apu_addr_d[c] = prog_bases[c*ADDR_W +: ADDR_W];
                for (int s = 0; s < LOOP_SLOTS; s++) begin
                    strides_d[c][s] = prog_strides[(c*LOOP_SLOTS+s)*ADDR_W +: ADDR_W];
                end
            end
            depth_d = '0;
            error_d = 1'b0;
            state_d = READY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            stack_q     <= '{default: '0};
            depth_q     <= '0;
            apu_idx_q   <= '0;
            slot_q      <= '0;
            pc_q        <= '0;
            rsp_pc_q    <= '0;
            rsp_jump_q  <= 1'b0;
            rsp_error_q <= 1'b0;
            error_q     <= 1'b0;
            iters_q     <= '{default: '0};
            strides_q   <= '{default: '{default: '0}};
            bases_q     <= '{default: '0};
            acc_q       <= '{default: '0};
            apu_addr_q  <= '{default: '0};
        end else begin
            state_q     <= state_d;
            stack_q     <= stack_d;
            depth_q     <= depth_d;
            apu_idx_q   <= apu_idx_d;
            slot_q      <= slot_d;
            pc_q        <= pc_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_jump_q  <= rsp_jump_d;
            rsp_error_q <= rsp_error_d;
            error_q     <= error_d;
            iters_q     <= iters_d;
            strides_q   <= strides_d;
            bases_q     <= bases_d;
            acc_q       <= acc_d;
            apu_addr_q  <= apu_addr_d;
        end
    end

    assign cmd_ready  = (state_q == READY);
    assign rsp_valid  = (state_q == RESPOND);
    assign rsp_jump   = rsp_valid & rsp_jump_q;
    assign rsp_error  = rsp_valid & rsp_error_q;
    assign rsp_pc     = rsp_valid ? rsp_pc_q : '0;
    assign loop_depth = depth_q;
    assign error      = error_q;

endmodule

// File: tb/tb_loop_apu_engine.sv
// Randomised and directed bench for loop_apu_engine against a queue-based loop-stack model.
module tb_loop_apu_engine;

    localparam int LOG_LOOP_CNT = 3;
    localparam int LOOP_SLOTS   = 8;
    localparam int STACK_DEPTH  = 4;
    localparam int NUM_APU      = 4;
    localparam int ADDR_W       = 18;
    localparam int ITER_W       = 12;
    localparam int PC_W         = 16;
    localparam int DEPTH_W      = 3;

    logic                                 clk = 1'b0;
    logic                                 reset;
    logic                                 prog_load;
    logic [LOOP_SLOTS*ITER_W-1:0]         prog_iters;
    logic [NUM_APU*LOOP_SLOTS*ADDR_W-1:0] prog_strides;
    logic [NUM_APU*ADDR_W-1:0]            prog_bases;
    logic                                 cmd_valid;
    logic                                 cmd_ready;
    logic                                 cmd_op;
    logic [LOG_LOOP_CNT-1:0]              cmd_loop_addr;
    logic [PC_W-1:0]                      cmd_pc;
    logic                                 rsp_valid;
    logic                                 rsp_jump;
    logic [PC_W-1:0]                      rsp_pc;
    logic                                 rsp_error;
    logic [NUM_APU*ADDR_W-1:0]            apu_addr;
    logic [DEPTH_W-1:0]                   loop_depth;
    logic                                 error;

    loop_apu_engine dut (
        .clk          (clk),
        .reset        (reset),
        .prog_load    (prog_load),
        .prog_iters   (prog_iters),
        .prog_strides (prog_strides),
        .prog_bases   (prog_bases),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_loop_addr(cmd_loop_addr),
        .cmd_pc       (cmd_pc),
        .rsp_valid    (rsp_valid),
        .rsp_jump     (rsp_jump),
        .rsp_pc       (rsp_pc),
        .rsp_error    (rsp_error),
        .apu_addr     (apu_addr),
        .loop_depth   (loop_depth),
        .error        (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int unsigned     m_iters  [LOOP_SLOTS];
    longint unsigned m_stride [NUM_APU][LOOP_SLOTS];
    longint unsigned m_base   [NUM_APU];
    int unsigned     m_slot[$];
    int unsigned     m_spc[$];
    int unsigned     m_var[$];
    bit              m_err;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Address of channel c given the model's loop stack.
    function automatic longint unsigned model_addr(input int c);
        longint unsigned a;
        a = m_base[c];
        for (int l = 0; l < m_slot.size(); l++) begin
            a = (a + m_stride[c][m_slot[l]] * m_var[l]) % (64'd1 << ADDR_W);
        end
        return a;
    endfunction

    task automatic clear_cfg();
        for (int s = 0; s < LOOP_SLOTS; s++) m_iters[s] = 0;
        for (int c = 0; c < NUM_APU; c++) begin
            m_base[c] = 0;
            for (int s = 0; s < LOOP_SLOTS; s++) m_stride[c][s] = 0;
        end
    endtask

    task automatic rand_cfg();
        for (int s = 0; s < LOOP_SLOTS; s++) m_iters[s] = $urandom_range(0, 4);
        for (int c = 0; c < NUM_APU; c++) begin
            m_base[c] = $urandom_range(0, (1 << ADDR_W) - 1);
            for (int s = 0; s < LOOP_SLOTS; s++) m_stride[c][s] = $urandom_range(0, (1 << ADDR_W) - 1);
        end
    endtask

    task automatic load_prog();
        for (int s = 0; s < LOOP_SLOTS; s++) prog_iters[s*ITER_W +: ITER_W] = ITER_W'(m_iters[s]);
        for (int c = 0; c < NUM_APU; c++) begin
            prog_bases[c*ADDR_W +: ADDR_W] = ADDR_W'(m_base[c]);
            for (int s = 0; s < LOOP_SLOTS; s++)
                prog_strides[(c*LOOP_SLOTS+s)*ADDR_W +: ADDR_W] = ADDR_W'(m_stride[c][s]);
        end
        @(negedge clk);
        prog_load = 1'b1;
        @(negedge clk);
        prog_load = 1'b0;
        m_slot.delete();
        m_spc.delete();
        m_var.delete();
        m_err = 1'b0;
        chk("load_ready", cmd_ready, 1);
        chk("load_depth", loop_depth, 0);
        chk("load_error", error, 0);
        for (int c = 0; c < NUM_APU; c++)
            chk($sformatf("load_addr%0d", c), apu_addr[c*ADDR_W +: ADDR_W], m_base[c]);
        $display("load  bases=%05h %05h %05h %05h", m_base[0], m_base[1], m_base[2], m_base[3]);
    endtask

    task automatic do_cmd(input bit op, input int unsigned slot, input int unsigned pc);
        int unsigned exp_pc;
        int unsigned eff;
        int          t;
        int          cyc;
        int          lat;
        bit          exp_jump;
        bit          exp_err;

        exp_err  = 1'b0;
        exp_jump = 1'b0;
        exp_pc   = (pc + 1) % (1 << PC_W);
        if (op == 1'b0) begin
            if (m_slot.size() == STACK_DEPTH) begin
                exp_err = 1'b1;
            end else begin
                m_slot.push_back(slot);
                m_spc.push_back(pc);
                m_var.push_back(0);
            end
        end else if (m_slot.size() == 0) begin
            exp_err = 1'b1;
        end else begin
            t   = m_slot.size() - 1;
            eff = (m_iters[m_slot[t]] == 0) ? 1 : m_iters[m_slot[t]];
            if (m_var[t] + 1 < eff) begin
                m_var[t]++;
                exp_jump = 1'b1;
                exp_pc   = (m_spc[t] + 1) % (1 << PC_W);
            end else begin
                void'(m_slot.pop_back());
                void'(m_spc.pop_back());
                void'(m_var.pop_back());
            end
        end
        if (exp_err) m_err = 1'b1;
        lat = exp_err ? 2 : 2 + ((m_slot.size() == 0) ? 1 : m_slot.size());

        @(negedge clk);
        cmd_valid     = 1'b1;
        cmd_op        = op;
        cmd_loop_addr = LOG_LOOP_CNT'(slot);
        cmd_pc        = PC_W'(pc);
        chk("hs_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("rsp_seen", rsp_valid, 1);
        chk("latency", cyc, lat);
        chk("rsp_pc", rsp_pc, exp_pc);
        chk("rsp_jump", rsp_jump, exp_jump);
        chk("rsp_error", rsp_error, exp_err);
        chk("loop_depth", loop_depth, m_slot.size());
        chk("error_flag", error, m_err);
        for (int c = 0; c < NUM_APU; c++)
            chk($sformatf("addr%0d", c), apu_addr[c*ADDR_W +: ADDR_W], model_addr(c));
        $display("cmd   op=%0d slot=%0d pc=%04h -> pc=%04h jump=%0d err=%0d lat=%0d depth=%0d addr0=%05h",
                 op, slot, pc, rsp_pc, rsp_jump, rsp_error, cyc, loop_depth, apu_addr[ADDR_W-1:0]);
        @(negedge clk);
        chk("rsp_pulse", rsp_valid, 0);
        chk("ready_back", cmd_ready, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        prog_load     = 1'b0;
        prog_iters    = '0;
        prog_strides  = '0;
        prog_bases    = '0;
        cmd_valid     = 1'b0;
        cmd_op        = 1'b0;
        cmd_loop_addr = '0;
        cmd_pc        = '0;
        m_err         = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_jump", rsp_jump, 0);
        chk("rst_rsp_pc", rsp_pc, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_depth", loop_depth, 0);
        chk("rst_error", error, 0);
        for (int c = 0; c < NUM_APU; c++)
            chk($sformatf("rst_addr%0d", c), apu_addr[c*ADDR_W +: ADDR_W], 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", cmd_ready, 0);

        // Single loop, three iterations.
        clear_cfg();
        m_iters[0] = 3;
        m_stride[0][0] = 2;
        load_prog();
        do_cmd(1'b0, 0, 6);
        repeat (3) do_cmd(1'b1, 0, 8);

        // Two-level nest run to completion.
        clear_cfg();
        m_iters[1] = 2;
        m_stride[0][1] = 10;
        m_iters[2] = 3;
        m_stride[0][2] = 1;
        load_prog();
        do_cmd(1'b0, 1, 20);
        repeat (2) begin
            do_cmd(1'b0, 2, 21);
            repeat (3) do_cmd(1'b1, 2, 23);
            do_cmd(1'b1, 1, 24);
        end

        // Overflow: one START more than the stack holds.
        rand_cfg();
        load_prog();
        for (int i = 0; i <= STACK_DEPTH; i++) do_cmd(1'b0, i, 100 + i);

        // Underflow with PC wrap.
        load_prog();
        do_cmd(1'b1, 0, 16'hFFFF);
        do_cmd(1'b1, 3, 16'h0010);

        // Address wrap modulo 2**ADDR_W.
        clear_cfg();
        m_base[0] = (1 << ADDR_W) - 1;
        m_stride[0][0] = 1;
        m_iters[0] = 2;
        load_prog();
        do_cmd(1'b0, 0, 40);
        do_cmd(1'b1, 0, 41);

        // Random command streams.
        for (int blk = 0; blk < 5; blk++) begin
            rand_cfg();
            load_prog();
            for (int i = 0; i < 50; i++)
                do_cmd(1'($urandom_range(0, 1)), $urandom_range(0, LOOP_SLOTS - 1), $urandom_range(0, 65535));
        end

        // Reset during an APU phase at depth 2.
        rand_cfg();
        load_prog();
        do_cmd(1'b0, 1, 200);
        @(negedge clk);
        cmd_valid     = 1'b1;
        cmd_op        = 1'b0;
        cmd_loop_addr = 3'd2;
        cmd_pc        = 16'd201;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_depth", loop_depth, 2);
        chk("mid_no_rsp", rsp_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_ready", cmd_ready, 0);
        chk("mrst_depth", loop_depth, 0);
        chk("mrst_error", error, 0);
        for (int c = 0; c < NUM_APU; c++)
            chk($sformatf("mrst_addr%0d", c), apu_addr[c*ADDR_W +: ADDR_W], 0);
        for (int i = 0; i < 4; i++) begin
            chk("mrst_rsp", rsp_valid, 0);
            @(negedge clk);
        end
        $display("reset mid-APU: depth=%0d ready=%0d", loop_depth, cmd_ready);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
